// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: operation encoding
// and the slice-width helper used to split the operand across pipeline stages.
package pipelined_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Number of operand bits handled by each pipeline stage.
    function automatic int sw(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// Combinational building blocks: a half adder, and a carry-chained slice of
// full adders (each made from two half adders plus an OR) that also exposes
// the carry into its MSB so the final slice can derive signed overflow.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

module adder_slice #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          c_in,
    output logic [SW-1:0] sum,
    output logic          c_out,
    output logic          c_msb_in
);

    // c[i] is the carry into bit i; c[SW] leaves the slice.
    logic [SW:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < SW; i++) begin : g_fa
        logic s_ab;
        logic c_ab;
        logic c_sc;

        half_adder u_ha_ab (
            .a    (a[i]),
            .b    (b[i]),
            .sum  (s_ab),
            .carry(c_ab)
        );

        half_adder u_ha_c (
            .a    (s_ab),
            .b    (c[i]),
            .sum  (sum[i]),
            .carry(c_sc)
        );

        assign c[i+1] = c_ab | c_sc;
    end

    assign c_out    = c[SW];
    assign c_msb_in = c[SW-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement add/subtract. The operand is cut into STAGES
// slices; slice k is added in stage k using the carry registered by stage k-1.
// Not-yet-consumed operand bits and already-completed low sum bits travel in
// the stage registers. The whole pipe advances as one unit under valid/ready.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int SW = sw(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
        $error("pipelined_adder: STAGES must be in 1..WIDTH");
    end
    if (WIDTH % STAGES != 0) begin : g_bad_split
        $error("pipelined_adder: WIDTH must be divisible by STAGES");
    end

    logic advance;

    // Stage registers; index k holds the state leaving stage k.
    logic [STAGES-1:0]            vld_p;
    logic [STAGES-1:0][WIDTH-1:0] op_a_p;
    logic [STAGES-1:0][WIDTH-1:0] op_b_p;
    logic [STAGES-1:0][WIDTH-1:0] sum_p;
    logic [STAGES-1:0]            carry_p;

    // Inputs seen by each stage's slice adder.
    logic [STAGES-1:0][WIDTH-1:0] st_a;
    logic [STAGES-1:0][WIDTH-1:0] st_b;
    logic [STAGES-1:0][WIDTH-1:0] st_s;
    logic [STAGES-1:0]            st_c;

    logic [STAGES-1:0][SW-1:0]    slc_sum;
    logic [STAGES-1:0]            slc_cout;
    logic [STAGES-1:0]            slc_cmsb;
    logic [STAGES-1:0][WIDTH-1:0] nxt_sum;

    // The last stage's operand/partial copies and lower-slice MSB carries
    // have no consumer; gathering them here keeps that explicit.
    logic unused_bits;
    assign unused_bits = ^{op_a_p[STAGES-1], op_b_p[STAGES-1], sum_p[STAGES-1],
                           carry_p[STAGES-1], slc_cmsb};

    assign out_valid = vld_p[STAGES-1];
    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;

    // Stage 0 takes the raw operands (B inverted and carry forced for subtract);
    // later stages take the previous stage's registers.
    always_comb begin
        st_a    = '0;
        st_b    = '0;
        st_s    = '0;
        st_c    = '0;
        st_a[0] = a;
        st_b[0] = (sub == OP_SUB) ? ~b : b;
        st_c[0] = (sub == OP_SUB) ? 1'b1 : c_in;
        for (int k = 1; k < STAGES; k++) begin
            st_a[k] = op_a_p[k-1];
            st_b[k] = op_b_p[k-1];
            st_s[k] = sum_p[k-1];
            st_c[k] = carry_p[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_slice #(.SW(SW)) u_slice (
            .a       (st_a[k][k*SW +: SW]),
            .b       (st_b[k][k*SW +: SW]),
            .c_in    (st_c[k]),
            .sum     (slc_sum[k]),
            .c_out   (slc_cout[k]),
            .c_msb_in(slc_cmsb[k])
        );
    end

    // Merge each stage's freshly computed slice into the accumulated low bits.
    always_comb begin
        nxt_sum = st_s;
        for (int k = 0; k < STAGES; k++) begin
            nxt_sum[k][k*SW +: SW] = slc_sum[k];
        end
    end

    // Intermediate datapath registers: no reset, load whenever the pipe moves.
    always_ff @(posedge clk) begin
        if (advance) begin
            op_a_p  <= st_a;
            op_b_p  <= st_b;
            sum_p   <= nxt_sum;
            carry_p <= slc_cout;
        end
    end

    // Valid chain and result registers; flush kills every in-flight op and the offered one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (flush) begin
                vld_p <= '0;
            end else if (advance) begin
                vld_p <= (vld_p << 1) | STAGES'(in_valid);
            end
            if (advance) begin
                sum   <= nxt_sum[STAGES-1];
                c_out <= slc_cout[STAGES-1];
                ovf   <= slc_cout[STAGES-1] ^ slc_cmsb[STAGES-1];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: three instances (STAGES 4, 1, 32) share stimulus;
// each keeps its own scoreboard of expected results in acceptance order.
module tb_pipelined_adder;

    localparam int ND = 3;
    localparam longint SMAX = 64'sh7FFFFFFF;
    localparam longint SMIN = -SMAX - 1;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic        sub;
    logic        c_in;
    logic [31:0] a;
    logic [31:0] b;

    logic [31:0] o_sum  [ND];
    logic        o_cout [ND];
    logic        o_ovf  [ND];
    logic        o_vld  [ND];
    logic        o_rdy  [ND];

    int   stg [ND] = '{4, 1, 32};
    res_t sb [ND][$];
    res_t cur_exp;
    logic lat_chk;
    int   cyc;
    int   n_cmp;
    int   n_fail;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(o_rdy[0]),
        .a(a), .b(b), .sub(sub), .c_in(c_in), .out_valid(o_vld[0]), .out_ready(out_ready),
        .sum(o_sum[0]), .c_out(o_cout[0]), .ovf(o_ovf[0])
    );

    pipelined_adder #(.WIDTH(32), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(o_rdy[1]),
        .a(a), .b(b), .sub(sub), .c_in(c_in), .out_valid(o_vld[1]), .out_ready(out_ready),
        .sum(o_sum[1]), .c_out(o_cout[1]), .ovf(o_ovf[1])
    );

    pipelined_adder #(.WIDTH(32), .STAGES(32)) u_s32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(o_rdy[2]),
        .a(a), .b(b), .sub(sub), .c_in(c_in), .out_valid(o_vld[2]), .out_ready(out_ready),
        .sum(o_sum[2]), .c_out(o_cout[2]), .ovf(o_ovf[2])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d (STAGES=%0d): got %0h, want %0h", name, d, stg[d], act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic s, input logic ci);
        res_t   r;
        longint sx;
        longint sy;
        longint sr;
        logic [32:0] w;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            r.sum  = x - y;
            r.cout = (x >= y);
            sr     = sx - sy;
        end else begin
            w      = {1'b0, x} + {1'b0, y} + {32'd0, ci};
            r.sum  = w[31:0];
            r.cout = w[32];
            sr     = sx + sy + longint'(ci);
        end
        r.ovf = (sr > SMAX) || (sr < SMIN);
        r.cyc = 0;
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    // One clock: scoreboard work on the falling edge, then return just after the rising edge.
    task automatic step();
        res_t e;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            if (!rst_n || flush) begin
                sb[d].delete();
            end else begin
                if (o_vld[d] && out_ready) begin
                    if (sb[d].size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected dut%0d (STAGES=%0d): got result %0h, want none", d, stg[d], o_sum[d]);
                    end else begin
                        e = sb[d].pop_front();
                        chk("result{c_out,ovf,sum}", d, 64'({o_cout[d], o_ovf[d], o_sum[d]}),
                            64'({e.cout, e.ovf, e.sum}));
                        if (lat_chk) chk("latency", d, 64'(cyc - e.cyc), 64'(stg[d]));
                    end
                end
                if (in_valid && o_rdy[d]) begin
                    e     = cur_exp;
                    e.cyc = cyc;
                    sb[d].push_back(e);
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic s,
                         input logic ci, input res_t exp);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        sub      = s;
        c_in     = ci;
        cur_exp  = exp;
    endtask

    task automatic drive_rand();
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        logic        ci;
        x  = pick();
        y  = pick();
        s  = 1'($urandom_range(0, 1));
        ci = 1'($urandom_range(0, 1));
        drive(x, y, s, ci, model(x, y, s, ci));
    endtask

    task automatic drain();
        int pending;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            pending = sb[0].size() + sb[1].size() + sb[2].size();
            if (pending == 0) break;
            step();
        end
        pending = sb[0].size() + sb[1].size() + sb[2].size();
        chk("drain_outstanding", 0, 64'(pending), 64'd0);
    endtask

    initial begin
        vec_t        tbl [10];
        res_t        r;
        logic [31:0] hold [ND];

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0; c_in = 1'b0;
        lat_chk = 1'b0; cyc = 0; n_cmp = 0; n_fail = 0;
        cur_exp = '{sum: 32'd0, cout: 1'b0, ovf: 1'b0, cyc: 0};

        tbl[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tbl[4] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        tbl[6] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
        tbl[8] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        tbl[9] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1};

        // Power-on reset: outputs must read zero while held.
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++)
            chk("reset_outputs", d, 64'({o_vld[d], o_cout[d], o_ovf[d], o_sum[d]}), 64'd0);
        rst_n = 1'b1;
        step();
        for (int d = 0; d < ND; d++) begin
            chk("in_ready_after_reset", d, 64'(o_rdy[d]), 64'd1);
            chk("out_valid_after_reset", d, 64'(o_vld[d]), 64'd0);
        end

        // Directed vectors, back to back, with latency checking.
        lat_chk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            r = '{sum: tbl[i].sum, cout: tbl[i].cout, ovf: tbl[i].ovf, cyc: 0};
            drive(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin, r);
            step();
        end
        drain();
        lat_chk = 1'b0;

        // 100 random back-to-back ops against the reference model.
        for (int i = 0; i < 100; i++) begin
            drive_rand();
            step();
        end
        drain();

        // Backpressure: fill every pipe with out_ready low, then hold 5 cycles.
        out_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            drive_rand();
            step();
        end
        for (int d = 0; d < ND; d++) hold[d] = o_sum[d];
        for (int i = 0; i < 5; i++) begin
            drive_rand();
            step();
            for (int d = 0; d < ND; d++) begin
                chk("stall_in_ready", d, 64'(o_rdy[d]), 64'd0);
                chk("stall_out_valid", d, 64'(o_vld[d]), 64'd1);
                chk("stall_sum_stable", d, 64'(o_sum[d]), 64'(hold[d]));
            end
        end
        drain();

        // Flush with two ops in flight and a third offered in the flush cycle.
        drive_rand();
        step();
        drive_rand();
        step();
        drive_rand();
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            for (int d = 0; d < ND; d++) chk("flush_no_output", d, 64'(o_vld[d]), 64'd0);
        end
        lat_chk = 1'b1;
        drive_rand();
        step();
        drain();
        lat_chk = 1'b0;

        // Asynchronous reset with three ops in flight.
        for (int i = 0; i < 3; i++) begin
            drive(32'h0000_1000 + 32'(i), 32'h0000_0100, 1'b0, 1'b0,
                  model(32'h0000_1000 + 32'(i), 32'h0000_0100, 1'b0, 1'b0));
            step();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++)
            chk("async_reset_outputs", d, 64'({o_vld[d], o_cout[d], o_ovf[d], o_sum[d]}), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) step();
        for (int d = 0; d < ND; d++) chk("no_stale_after_reset", d, 64'(o_vld[d]), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
